// File: rtl/mdio_controller_if.sv
// MDIO controller bus: host request/response signals plus the MDC/MDIO line pins.
// master = controller side, slave = host/PHY side.
interface mdio_controller_if;
    logic [31:0] T_DATA;
    logic        T_STB;
    logic        MDIO_IN;
    logic        MDC;
    logic        MDIO_OE;
    logic        MDIO_OUT;
    logic [15:0] RD_DATA;
    logic        DATA_RDY;
    logic        BUSY;

    modport master (
        input  T_DATA, T_STB, MDIO_IN,
        output MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY
    );

    modport slave (
        output T_DATA, T_STB, MDIO_IN,
        input  MDC, MDIO_OE, MDIO_OUT, RD_DATA, DATA_RDY, BUSY
    );
endinterface

// File: rtl/mdio_controller.sv
// MDIO station-management master: free-running MDC, 32-bit frame serialiser, read capture.
// Define MDIO_PREAMBLE_EN to prepend 32 MDC periods of driven ones to every frame.
module mdio_controller #(
    parameter int unsigned MDC_HALF = 4
) (
    input logic               clk,
    input logic               reset,
    mdio_controller_if.master bus
);
    localparam int unsigned DivW = (MDC_HALF > 2) ? $clog2(MDC_HALF) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(MDC_HALF - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitEdge,
`ifdef MDIO_PREAMBLE_EN
        StPreamble,
`endif
        StSend,
        StRead,
        StDone
    } state_t;

    state_t         r_state, w_state;
    logic [DivW-1:0] r_div;
    logic           r_mdc;
    logic [31:0]    r_shift, w_shift;
    logic           r_is_read, w_is_read;
    logic [5:0]     r_cnt, w_cnt;
    logic           r_oe, w_oe;
    logic           r_out, w_out;
    logic           r_busy, w_busy;
    logic [14:0]    r_rx, w_rx;
    logic [15:0]    r_rd_data, w_rd_data;
    logic           r_rdy, w_rdy;

    logic w_tick, w_fall, w_rise;

    assign w_tick = (r_div == DivLast);
    assign w_fall = w_tick & r_mdc;
    assign w_rise = w_tick & ~r_mdc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div     <= '0;
            r_mdc     <= 1'b0;
            r_state   <= StIdle;
            r_shift   <= '0;
            r_is_read <= 1'b0;
            r_cnt     <= '0;
            r_oe      <= 1'b0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_rx      <= '0;
            r_rd_data <= '0;
            r_rdy     <= 1'b0;
        end else begin
            r_div     <= w_tick ? '0 : r_div + DivW'(1);
            r_mdc     <= w_tick ? ~r_mdc : r_mdc;
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_is_read <= w_is_read;
            r_cnt     <= w_cnt;
            r_oe      <= w_oe;
            r_out     <= w_out;
            r_busy    <= w_busy;
            r_rx      <= w_rx;
            r_rd_data <= w_rd_data;
            r_rdy     <= w_rdy;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_is_read = r_is_read;
        w_cnt     = r_cnt;
        w_oe      = r_oe;
        w_out     = r_out;
        w_busy    = r_busy;
        w_rx      = r_rx;
        w_rd_data = r_rd_data;
        w_rdy     = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (bus.T_STB) begin
                    w_shift   = bus.T_DATA;
                    w_is_read = (bus.T_DATA[29:28] == 2'b10);
                    w_cnt     = '0;
                    w_busy    = 1'b1;
                    w_state   = StWaitEdge;
                end
            end
            StWaitEdge: begin
                if (w_fall) begin
                    w_oe = 1'b1;
`ifdef MDIO_PREAMBLE_EN
                    w_out   = 1'b1;
                    w_cnt   = 6'd1;
                    w_state = StPreamble;
`else
                    w_out   = r_shift[31];
                    w_shift = {r_shift[30:0], 1'b0};
                    w_cnt   = 6'd1;
                    w_state = StSend;
`endif
                end
            end
`ifdef MDIO_PREAMBLE_EN
            StPreamble: begin
                if (w_fall) begin
                    if (r_cnt == 6'd32) begin
                        w_out   = r_shift[31];
                        w_shift = {r_shift[30:0], 1'b0};
                        w_cnt   = 6'd1;
                        w_state = StSend;
                    end else begin
                        w_cnt = r_cnt + 6'd1;
                    end
                end
            end
`endif
            StSend: begin
                // r_cnt counts bits already on the line; the fall after the last one ends SEND
                if (w_fall) begin
                    if (r_is_read && r_cnt == 6'd16) begin
                        w_oe    = 1'b0;
                        w_out   = 1'b0;
                        w_cnt   = '0;
                        w_state = StRead;
                    end else if (!r_is_read && r_cnt == 6'd32) begin
                        w_oe    = 1'b0;
                        w_out   = 1'b0;
                        w_state = StDone;
                    end else begin
                        w_out   = r_shift[31];
                        w_shift = {r_shift[30:0], 1'b0};
                        w_cnt   = r_cnt + 6'd1;
                    end
                end
            end
            StRead: begin
                if (w_rise) begin
                    w_rx  = {r_rx[13:0], bus.MDIO_IN};
                    w_cnt = r_cnt + 6'd1;
                    if (r_cnt == 6'd15) begin
                        w_rd_data = {r_rx, bus.MDIO_IN};
                        w_rdy     = 1'b1;
                        w_state   = StDone;
                    end
                end
            end
            StDone: begin
                if (w_fall) begin
                    w_oe    = 1'b0;
                    w_out   = 1'b0;
                    w_busy  = 1'b0;
                    w_state = StIdle;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign bus.MDC      = r_mdc;
    assign bus.MDIO_OE  = r_oe;
    assign bus.MDIO_OUT = r_out;
    assign bus.RD_DATA  = r_rd_data;
    assign bus.DATA_RDY = r_rdy;
    assign bus.BUSY     = r_busy;
endmodule

// File: tb/tb_mdio_controller.sv
// Self-checking bench for mdio_controller: table vectors, random frames, busy reject, reset abort,
// plus MDC_HALF=2/7 instances watched for period and edge alignment.
module tb_mdio_controller;
    localparam int unsigned H = 4;
`ifdef MDIO_PREAMBLE_EN
    localparam int PRE = 32;
`else
    localparam int PRE = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdio_controller_if bus ();
    mdio_controller #(.MDC_HALF(H)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    for (genvar g = 0; g < 2; g++) begin : g_x
        localparam int unsigned XH = (g == 0) ? 2 : 7;
        mdio_controller_if xb ();
        logic pm = 1'b0, poe = 1'b0, pout = 1'b0, seen = 1'b0;
        int   cnt = 0, viol = 0, frames = 0;
        assign xb.T_DATA  = bus.T_DATA;
        assign xb.T_STB   = bus.T_STB;
        assign xb.MDIO_IN = 1'b0;
        mdio_controller #(.MDC_HALF(XH)) u_x (.clk(clk), .reset(reset), .bus(xb));
        always @(negedge clk) begin
            pm   <= xb.MDC;
            poe  <= xb.MDIO_OE;
            pout <= xb.MDIO_OUT;
            if (reset) begin
                seen <= 1'b0;
                cnt  <= 0;
            end else begin
                if (xb.MDC && !pm) begin
                    if (seen && cnt != int'(2 * XH)) viol <= viol + 1;
                    seen <= 1'b1;
                    cnt  <= 1;
                end else begin
                    cnt <= cnt + 1;
                end
                if ((xb.MDIO_OE != poe || xb.MDIO_OUT != pout) && !(pm && !xb.MDC))
                    viol <= viol + 1;
                if (xb.MDIO_OE && !poe) frames <= frames + 1;
            end
        end
    end

    typedef struct {
        logic [31:0] frame;
        logic [15:0] phy;
        int          exp_rdy;
        logic [15:0] exp_rd;
    } vec_t;

    int   n_err = 0, n_checks = 0;
    bit   rec_oe[$], rec_out[$], exp_q[$];
    int   rdy_n, align_viol;
    logic [15:0] model_rd;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected line content per MDC period, straight from the frame layout.
    task automatic build_expect(input logic [31:0] f);
        int nb;
        exp_q.delete();
        for (int i = 0; i < PRE; i++) exp_q.push_back(1'b1);
        nb = (f[29:28] == 2'b10) ? 16 : 32;
        for (int i = 0; i < nb; i++) exp_q.push_back(f[31-i]);
    endtask

    task automatic run_frame(input logic [31:0] frame, input logic [15:0] phy, input int inject_at,
                             input logic [31:0] inj, input int abort_bits);
        int   t, idx, trail;
        logic pm, poe, pout;
        bit   cap;
        rec_oe.delete();
        rec_out.delete();
        rdy_n = 0; align_viol = 0; idx = 0; trail = 0; cap = 1'b0;
        bus.MDIO_IN = 1'b0;
        t = 0;
        while (bus.BUSY && t < 5000) begin @(negedge clk); t++; end
        bus.T_DATA = frame;
        bus.T_STB  = 1'b1;
        @(negedge clk);
        bus.T_STB  = 1'b0;
        bus.T_DATA = $urandom;
        check("busy_set", bus.BUSY, 1);
        pm = bus.MDC; poe = bus.MDIO_OE; pout = bus.MDIO_OUT;
        t = 0;
        while (bus.BUSY && t < 20000) begin
            @(negedge clk);
            t++;
            if (bus.DATA_RDY) rdy_n++;
            if ((bus.MDIO_OE != poe || bus.MDIO_OUT != pout) && !(pm && !bus.MDC)) align_viol++;
            if (!pm && bus.MDC) begin
                if (bus.MDIO_OE) cap = 1'b1;
                if (cap) begin
                    rec_oe.push_back(bus.MDIO_OE);
                    rec_out.push_back(bus.MDIO_OUT);
                    if (!bus.MDIO_OE) trail++;
                end
            end
            // PHY model: present the next data bit after each MDC fall once the line is released
            if (pm && !bus.MDC && cap && !bus.MDIO_OE && idx < 16) begin
                bus.MDIO_IN = phy[15-idx];
                idx++;
            end
            if (t == inject_at) begin
                bus.T_DATA = inj;
                bus.T_STB  = 1'b1;
            end else begin
                bus.T_STB = 1'b0;
            end
            pm = bus.MDC; poe = bus.MDIO_OE; pout = bus.MDIO_OUT;
            if (abort_bits >= 0 && trail == abort_bits) begin
                reset = 1'b1;
                #1;
                check("abort_mdc", bus.MDC, 0);
                check("abort_oe", bus.MDIO_OE, 0);
                check("abort_out", bus.MDIO_OUT, 0);
                check("abort_busy", bus.BUSY, 0);
                check("abort_rdy", bus.DATA_RDY, 0);
                return;
            end
        end
        bus.T_STB = 1'b0;
        check("frame_done", bus.BUSY, 0);
    endtask

    task automatic check_frame(input logic [31:0] f, input int exp_rdy, input logic [15:0] exp_rd);
        int          n, oe_cnt, rel;
        bit          rd;
        logic [63:0] got, ex;
        build_expect(f);
        n  = exp_q.size();
        rd = (f[29:28] == 2'b10);
        check("len", rec_out.size(), n + (rd ? 16 : 1));
        got = '0; ex = '0; oe_cnt = 0; rel = 0;
        for (int i = 0; i < n; i++) begin
            if (i < rec_out.size()) begin
                got = {got[62:0], rec_out[i]};
                oe_cnt += int'(rec_oe[i]);
            end
            ex = {ex[62:0], exp_q[i]};
        end
        check("bits", got, ex);
        check("oe_drive", oe_cnt, n);
        if (rd) begin
            for (int i = n; i < rec_oe.size(); i++) rel += int'(rec_oe[i]);
            check("oe_release", rel, 0);
        end
        check("rdy_pulses", rdy_n, exp_rdy);
        check("rd_data", bus.RD_DATA, exp_rd);
        check("edge_align", align_viol, 0);
    endtask

    initial begin
        vec_t        vecs [6];
        int          t;
        logic [31:0] f;
        logic [15:0] p;
        bit          rd;

        vecs[0] = '{32'h5A7A_BEEF, 16'h0000, 0, 16'h0000};
        vecs[1] = '{32'h6A7A_0000, 16'hC3A5, 1, 16'hC3A5};
        vecs[2] = '{32'h4123_5678, 16'hFFFF, 0, 16'hC3A5};
        vecs[3] = '{32'h7FFF_FFFF, 16'h1234, 0, 16'hC3A5};
        vecs[4] = '{32'h6BFF_FFFF, 16'h5A0F, 1, 16'h5A0F};
        vecs[5] = '{32'h5000_1234, 16'h0F0F, 0, 16'h5A0F};

        reset = 1'b1;
        bus.T_DATA = '0; bus.T_STB = 1'b0; bus.MDIO_IN = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mdc", bus.MDC, 0);
        check("rst_oe", bus.MDIO_OE, 0);
        check("rst_out", bus.MDIO_OUT, 0);
        check("rst_rd", bus.RD_DATA, 0);
        check("rst_rdy", bus.DATA_RDY, 0);
        check("rst_busy", bus.BUSY, 0);
        reset = 1'b0;
        model_rd = '0;
        t = 0;
        while (!bus.MDC && t < 100) begin @(negedge clk); t++; end
        check("first_rise", t, H);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].frame, vecs[i].phy, 0, '0, -1);
            check_frame(vecs[i].frame, vecs[i].exp_rdy, vecs[i].exp_rd);
            model_rd = vecs[i].exp_rd;
        end

        // Second request mid-write must be ignored, then accepted once idle.
        run_frame(32'h5A7A_BEEF, 16'h0000, 20, 32'h5000_1234, -1);
        check_frame(32'h5A7A_BEEF, 0, model_rd);
        run_frame(32'h5000_1234, 16'h0000, 0, '0, -1);
        check_frame(32'h5000_1234, 0, model_rd);

        // Back-to-back reads.
        for (int i = 0; i < 2; i++) begin
            p = 16'h8001 + 16'(i * 16'h1111);
            run_frame(32'h6000_0000, p, 0, '0, -1);
            check_frame(32'h6000_0000, 1, p);
            model_rd = p;
        end

        for (int i = 0; i < 8; i++) begin
            f = $urandom;
            if ($urandom_range(0, 1) == 1) f[29:28] = 2'b10;
            else if (f[29:28] == 2'b10) f[29:28] = 2'b01;
            p  = 16'($urandom);
            rd = (f[29:28] == 2'b10);
            run_frame(f, p, 0, '0, -1);
            if (rd) model_rd = p;
            check_frame(f, rd ? 1 : 0, model_rd);
        end

        // Reset after 8 read data bits: frame dropped, RD_DATA back to zero, no pulse.
        run_frame(32'h6A7A_0000, 16'hFFFF, 0, '0, 8);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rdy_n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.DATA_RDY) rdy_n++;
        end
        check("abort_no_rdy", rdy_n, 0);
        check("abort_rd_zero", bus.RD_DATA, 0);
        check("abort_idle", bus.BUSY, 0);

        check("h2_viol", g_x[0].viol, 0);
        check("h7_viol", g_x[1].viol, 0);
        check("h2_active", g_x[0].frames > 0, 1);
        check("h7_active", g_x[1].frames > 0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
